demux32_4_stream: RTL and testbench

- 1-to-4 routing block with valid/ready handshakes: the splitting counterpart to the 32-bit 4:1 select mux used in the datapath.
- Accepts one WIDTH-bit beat per cycle plus a 2-bit destination select, and steers it to one of four output channels.
- Each output channel has its own 2-entry FIFO, so a stalled consumer does not block the other three.
- Per-channel beat order is preserved. There is no ordering guarantee between channels.

---
 rtl/demux32_4_stream.sv | 91 +++++++++
 tb/tb_demux32_4_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demux32_4_stream.sv
// demux32_4_stream: 1-to-4 stream router with valid/ready handshakes.
// One input beat is steered to one of four output channels chosen by select_i.
// Each channel owns a 2-entry FIFO, so a stalled consumer never blocks the
// other channels. Beat order is kept within a channel, not across channels.
module demux32_4_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       select_i,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic [WIDTH-1:0] data3_o,
  output logic [WIDTH-1:0] data4_o,
  output logic [3:0]       valid_o,
  input  logic [3:0]       ready_i,
  output logic             busy_o
);

  // Per-channel FIFO state
  logic [1:0]       cnt_q [4];
  logic [1:0]       cnt_d [4];
  logic             rd_q  [4];
  logic             rd_d  [4];
  logic             wr_q  [4];
  logic             wr_d  [4];
  logic [WIDTH-1:0] mem_q [4][2];
  logic [WIDTH-1:0] head  [4];
  logic [3:0]       push;
  logic [3:0]       pop;

  // Input acceptance depends only on the registered count of the selected
  // channel, so there is no combinational path from ready_i to ready_o.
  always_comb begin
    ready_o = (cnt_q[select_i] != 2'd2);
  end

  // Push/pop decode, next-state counts and pointers, head selection.
  // While a channel is empty its head shows the entry most recently popped,
  // which is the slot behind the read pointer; that slot is not overwritten
  // until a second push, by which time the count is non-zero again.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      valid_o[k] = (cnt_q[k] != 2'd0);
      push[k]    = valid_i & ready_o & (select_i == 2'(k));
      pop[k]     = valid_o[k] & ready_i[k];
      cnt_d[k]   = cnt_q[k];
      rd_d[k]    = rd_q[k];
      wr_d[k]    = wr_q[k];
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
      if (push[k]) wr_d[k] = ~wr_q[k];
      if (pop[k])  rd_d[k] = ~rd_q[k];
      head[k] = valid_o[k] ? mem_q[k][rd_q[k]] : mem_q[k][~rd_q[k]];
    end
    busy_o = |valid_o;
  end

  assign data1_o = head[0];
  assign data2_o = head[1];
  assign data3_o = head[2];
  assign data4_o = head[3];

  // State update; reset empties every FIFO and clears storage so the
  // data outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k]    <= 2'd0;
        rd_q[k]     <= 1'b0;
        wr_q[k]     <= 1'b0;
        mem_q[k][0] <= '0;
        mem_q[k][1] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
        rd_q[k]  <= rd_d[k];
        wr_q[k]  <= wr_d[k];
        if (push[k]) mem_q[k][wr_q[k]] <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_demux32_4_stream.sv
// Directed self-checking bench for demux32_4_stream.
module tb_demux32_4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [1:0]  select_i;
  logic [31:0] data1_o, data2_o, data3_o, data4_o;
  logic [3:0]  valid_o;
  logic [3:0]  ready_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux32_4_stream #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .select_i (select_i),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .data3_o  (data3_o),
    .data4_o  (data4_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chan_data(input int i);
    case (i)
      0:       return data1_o;
      1:       return data2_o;
      2:       return data3_o;
      default: return data4_o;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 4'b0000; select_i = 2'b00; data_i = '0;

    // Reset then idle
    tick(); tick();
    chk("rst_valid", {28'd0, valid_o}, 32'h0);
    chk("rst_busy",  {31'd0, busy_o},  32'h0);
    chk("rst_ready", {31'd0, ready_o}, 32'h1);
    rst = 1'b0;
    tick();
    chk("idle_valid", {28'd0, valid_o}, 32'h0);
    chk("idle_busy",  {31'd0, busy_o},  32'h0);
    chk("idle_ready", {31'd0, ready_o}, 32'h1);
    chk("idle_d1", data1_o, 32'h0);
    chk("idle_d2", data2_o, 32'h0);
    chk("idle_d3", data3_o, 32'h0);
    chk("idle_d4", data4_o, 32'h0);

    // Single route to ch3
    valid_i = 1'b1; select_i = 2'b10; data_i = 32'hDEADBEEF;
    #1 chk("route_ready", {31'd0, ready_o}, 32'h1);
    tick();
    valid_i = 1'b0;
    #1;
    chk("route_valid", {28'd0, valid_o}, 32'h4);
    chk("route_d3",    data3_o,          32'hDEADBEEF);
    chk("route_busy",  {31'd0, busy_o},  32'h1);
    ready_i = 4'b0100;
    tick();
    ready_i = 4'b0000;
    #1;
    chk("route_pop_valid", {28'd0, valid_o}, 32'h0);
    chk("route_pop_busy",  {31'd0, busy_o},  32'h0);

    // Backpressure: fill ch1
    valid_i = 1'b1; select_i = 2'b00; data_i = 32'h11;
    tick();
    data_i = 32'h22;
    tick();
    valid_i = 1'b0; select_i = 2'b00;
    #1;
    chk("full_ready_ch1", {31'd0, ready_o}, 32'h0);
    chk("full_valid",     {28'd0, valid_o}, 32'h1);
    chk("full_d1_first",  data1_o,          32'h11);
    select_i = 2'b01;
    #1 chk("full_ready_ch2", {31'd0, ready_o}, 32'h1);
    // Full channel refuses a push even while its consumer pops
    valid_i = 1'b1; select_i = 2'b00; data_i = 32'h33; ready_i = 4'b0001;
    #1 chk("full_pop_ready", {31'd0, ready_o}, 32'h0);
    tick();
    valid_i = 1'b0; ready_i = 4'b0000;
    #1;
    chk("pop1_valid", {28'd0, valid_o}, 32'h1);
    chk("pop1_d1",    data1_o,          32'h22);
    chk("pop1_ready", {31'd0, ready_o}, 32'h1);
    ready_i = 4'b0001;
    tick();
    ready_i = 4'b0000;
    #1 chk("pop2_valid", {28'd0, valid_o}, 32'h0);

    // Simultaneous push/pop on ch4 at count 1
    valid_i = 1'b1; select_i = 2'b11; data_i = 32'hA;
    tick();
    data_i = 32'hB; ready_i = 4'b1000;
    #1;
    chk("pp_valid_before", {28'd0, valid_o}, 32'h8);
    chk("pp_d4_before",    data4_o,          32'hA);
    chk("pp_ready",        {31'd0, ready_o}, 32'h1);
    tick();
    valid_i = 1'b0; ready_i = 4'b0000;
    #1;
    chk("pp_valid_after", {28'd0, valid_o}, 32'h8);
    chk("pp_d4_after",    data4_o,          32'hB);
    chk("pp_ready_after", {31'd0, ready_o}, 32'h1);
    ready_i = 4'b1000;
    tick();
    ready_i = 4'b0000;
    #1 chk("pp_drain", {28'd0, valid_o}, 32'h0);

    // Interleaved channels, all consumers ready
    ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; select_i = 2'(i); data_i = 32'(i + 1);
      tick();
      chk($sformatf("il_valid%0d", i), {28'd0, valid_o}, 32'(1 << i));
      chk($sformatf("il_data%0d", i),  chan_data(i),     32'(i + 1));
    end
    valid_i = 1'b0;
    tick();
    chk("il_empty", {28'd0, valid_o}, 32'h0);

    // Reset mid-traffic discards buffered beats
    ready_i = 4'b0000;
    valid_i = 1'b1; select_i = 2'b01; data_i = 32'h55;
    tick();
    data_i = 32'h66;
    tick();
    valid_i = 1'b0;
    #1;
    chk("mr_valid_full", {28'd0, valid_o}, 32'h2);
    chk("mr_ready_full", {31'd0, ready_o}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", {28'd0, valid_o}, 32'h0);
    chk("mr_ready", {31'd0, ready_o}, 32'h1);
    chk("mr_busy",  {31'd0, busy_o},  32'h0);
    chk("mr_d2",    data2_o,          32'h0);
    ready_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_idle_valid%0d", i), {28'd0, valid_o}, 32'h0);
      chk($sformatf("mr_idle_d2_%0d", i),   data2_o,          32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
